uart_hex_print: RTL and testbench

Parametrised UART print engine. Accepts a value over a valid/ready handshake and emits it as ASCII hex on the `uart_tx` byte interface, with optional `0x` prefix, leading-zero suppression and CR/LF terminator. When idle, it forwards single echo bytes, normally from `uart_rx`. It sits between application logic and `uart_tx`, and replaces hand-written per-design print sequencers.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_hex_digit.sv | 13 +
 rtl/uart_hex_print.sv | 154 +++++++++++++++
 tb/tb_uart_hex_print.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and ASCII helpers for the hex print engine.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  localparam logic [7:0] CHAR_0    = 8'h30;
  localparam logic [7:0] CHAR_X    = 8'h78;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_A_UP = 8'h41;
  localparam logic [7:0] CHAR_A_LO = 8'h61;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble, input logic uppercase);
    logic [7:0] n8;
    n8 = {4'h0, nibble};
    if (nibble < 4'd10) return CHAR_0 + n8;
    return (uppercase ? CHAR_A_UP : CHAR_A_LO) + n8 - 8'd10;
  endfunction

endpackage

// File: rtl/uart_hex_digit.sv
// Combinational nibble to ASCII hex character.
module uart_hex_digit
  import uart_pkg::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  assign ascii_o = hex_ascii(nibble_i, UPPERCASE);

endmodule

// File: rtl/uart_hex_print.sv
// Prints a value as ASCII hex over a uart_tx byte interface; forwards echo bytes when idle.
//
// state    | meaning
// ST_IDLE  | req_ready high, waiting for a print request or an echo byte
// ST_START | uart_tx_start held with stable data until busy is seen high
// ST_BUSY  | waiting for the transmitter to drop busy
module uart_hex_print
  import uart_pkg::*;
#(
  parameter int VALUE_WIDTH    = 32,
  parameter int UPPERCASE      = 1,
  parameter int PREFIX_0X      = 0,
  parameter int SUPPRESS_ZEROS = 0,
  parameter int APPEND_CRLF    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   req_ready,
  input  logic                   echo_valid,
  input  logic [7:0]             echo_data,
  output logic                   echo_ready,
  output logic                   done,
  output logic                   uart_tx_start,
  output logic [7:0]             uart_tx_data,
  input  logic                   uart_tx_busy
);

  localparam int NDIG  = (VALUE_WIDTH + 3) / 4;
  localparam int PADW  = NDIG * 4;
  localparam int LEN_W = $clog2(NDIG + 4 + 1);

  localparam logic [LEN_W-1:0] NDIG_L = LEN_W'(NDIG);
  localparam logic [LEN_W-1:0] PRE_L  = LEN_W'((PREFIX_0X != 0) ? 2 : 0);
  localparam logic [LEN_W-1:0] CRLF_L = LEN_W'((APPEND_CRLF != 0) ? 2 : 0);
  localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);

  state_e           state_q;
  logic [PADW-1:0]  value_q;
  logic [LEN_W-1:0] skip_q, pos_q, len_q;
  logic             start_q, echo_ready_q, done_q;
  logic [7:0]       data_q;

  logic [PADW-1:0]  req_pad, sel_value;
  logic [LEN_W-1:0] skip_d, len_d, sel_skip, sel_pos, emit_n, digit_off, digit_idx;
  logic [3:0]       nibble;
  logic [7:0]       digit_ascii, byte_d;
  logic             found;

  assign req_pad = PADW'(req_value);

  // Leading-zero count at accept time; the last digit is never skipped.
  always_comb begin
    skip_d = '0;
    found  = 1'b0;
    if (SUPPRESS_ZEROS != 0) begin
      for (int k = NDIG - 1; k >= 1; k--) begin
        if (!found && (req_pad[4*k +: 4] == 4'h0)) skip_d = skip_d + ONE_L;
        else found = 1'b1;
      end
    end
  end

  assign len_d = PRE_L + (NDIG_L - skip_d) + CRLF_L;

  // In IDLE the first byte comes straight from the request; otherwise the next latched byte.
  assign sel_value = (state_q == ST_IDLE) ? req_pad : value_q;
  assign sel_skip  = (state_q == ST_IDLE) ? skip_d : skip_q;
  assign sel_pos   = (state_q == ST_IDLE) ? '0 : (pos_q + ONE_L);

  assign emit_n    = NDIG_L - sel_skip;
  assign digit_off = sel_pos - PRE_L + sel_skip;
  assign digit_idx = NDIG_L - ONE_L - digit_off;
  assign nibble    = 4'(sel_value >> {digit_idx, 2'b00});

  uart_hex_digit #(
    .UPPERCASE(UPPERCASE != 0)
  ) u_digit (
    .nibble_i(nibble),
    .ascii_o (digit_ascii)
  );

  always_comb begin
    byte_d = CHAR_LF;
    if ((PREFIX_0X != 0) && (sel_pos < LEN_W'(2))) byte_d = (sel_pos == '0) ? CHAR_0 : CHAR_X;
    else if (sel_pos < (PRE_L + emit_n))           byte_d = digit_ascii;
    else if (sel_pos == (PRE_L + emit_n))          byte_d = CHAR_CR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      data_q       <= 8'h00;
      echo_ready_q <= 1'b0;
      done_q       <= 1'b0;
      value_q      <= '0;
      skip_q       <= '0;
      pos_q        <= '0;
      len_q        <= '0;
    end else begin
      echo_ready_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            value_q <= req_pad;
            skip_q  <= skip_d;
            len_q   <= len_d;
            pos_q   <= '0;
            data_q  <= byte_d;
            start_q <= 1'b1;
            state_q <= ST_START;
          end else if (echo_valid) begin
            len_q        <= ONE_L;
            pos_q        <= '0;
            data_q       <= echo_data;
            echo_ready_q <= 1'b1;
            start_q      <= 1'b1;
            state_q      <= ST_START;
          end
        end
        ST_START: begin
          if (uart_tx_busy) begin
            start_q <= 1'b0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!uart_tx_busy) begin
            if ((pos_q + ONE_L) < len_q) begin
              pos_q   <= pos_q + ONE_L;
              data_q  <= byte_d;
              start_q <= 1'b1;
              state_q <= ST_START;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = rst_n && (state_q == ST_IDLE);
  assign echo_ready    = echo_ready_q;
  assign done          = done_q;
  assign uart_tx_start = start_q;
  assign uart_tx_data  = data_q;

endmodule

// File: tb/tb_uart_hex_print.sv
// Directed bench: three parameterisations of uart_hex_print, each driving a behavioural uart_tx.
module tb_uart_hex_print;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid  [3];
  logic [31:0] req_value [3];
  logic       echo_valid [3];
  logic [7:0] echo_data  [3];
  logic       req_ready  [3];
  logic       echo_ready [3];
  logic       done       [3];
  logic       start      [3];
  logic [7:0] data       [3];
  logic       busy       [3] = '{default: 1'b0};
  logic       stall_en   [3];

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         bcnt     [3] = '{default: 0};
  int         st_cnt   [3] = '{default: 0};
  logic [7:0] cap      [3][256];
  int         cap_n    [3] = '{default: 0};
  int         done_cnt [3] = '{default: 0};
  int         echo_cnt [3] = '{default: 0};
  int         viol_cnt [3] = '{default: 0};
  int         fall_cyc [3] = '{default: 0};
  logic       prev_start [3] = '{default: 1'b0};
  logic       prev_busy  [3] = '{default: 1'b0};
  logic [7:0] prev_data  [3] = '{default: 8'h00};

  uart_hex_print #(.VALUE_WIDTH(32), .PREFIX_0X(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_value(req_value[0]),
    .req_ready(req_ready[0]), .echo_valid(echo_valid[0]), .echo_data(echo_data[0]),
    .echo_ready(echo_ready[0]), .done(done[0]), .uart_tx_start(start[0]),
    .uart_tx_data(data[0]), .uart_tx_busy(busy[0]));

  uart_hex_print #(.VALUE_WIDTH(32), .SUPPRESS_ZEROS(1), .UPPERCASE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_value(req_value[1]),
    .req_ready(req_ready[1]), .echo_valid(echo_valid[1]), .echo_data(echo_data[1]),
    .echo_ready(echo_ready[1]), .done(done[1]), .uart_tx_start(start[1]),
    .uart_tx_data(data[1]), .uart_tx_busy(busy[1]));

  uart_hex_print #(.VALUE_WIDTH(10), .APPEND_CRLF(0)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_value(req_value[2][9:0]),
    .req_ready(req_ready[2]), .echo_valid(echo_valid[2]), .echo_data(echo_data[2]),
    .echo_ready(echo_ready[2]), .done(done[2]), .uart_tx_start(start[2]),
    .uart_tx_data(data[2]), .uart_tx_busy(busy[2]));

  // uart_tx model: busy rises one cycle after start (or after a stall), stays high 20 cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 3; g++) begin
      prev_start[g] <= start[g];
      prev_busy[g]  <= busy[g];
      prev_data[g]  <= data[g];
      if (done[g] === 1'b1) done_cnt[g] <= done_cnt[g] + 1;
      if (echo_ready[g] === 1'b1) echo_cnt[g] <= echo_cnt[g] + 1;
      if ((prev_start[g] && start[g] && (data[g] !== prev_data[g])) ||
          (prev_start[g] && prev_busy[g] && start[g]))
        viol_cnt[g] <= viol_cnt[g] + 1;
      if (!rst_n) begin
        busy[g]   <= 1'b0;
        bcnt[g]   <= 0;
        st_cnt[g] <= 0;
      end else if (busy[g]) begin
        if (bcnt[g] == 1) begin
          busy[g]     <= 1'b0;
          fall_cyc[g] <= cyc + 1;
        end
        bcnt[g] <= bcnt[g] - 1;
      end else if (start[g] === 1'b1) begin
        if (stall_en[g] && st_cnt[g] < 50) begin
          st_cnt[g] <= st_cnt[g] + 1;
        end else begin
          busy[g]  <= 1'b1;
          bcnt[g]  <= 20;
          st_cnt[g] <= 0;
          cap[g][cap_n[g]] <= data[g];
          cap_n[g] <= cap_n[g] + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int g, input string tag);
    int t;
    t = 0;
    while (done[g] !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, ".done_seen"}, 32'(done[g] === 1'b1), 32'd1);
  endtask

  task automatic run_print(input int g, input logic [31:0] val, input string exp, input string tag);
    int         base, dc0, t;
    logic [7:0] d0, eb;
    logic       hold_ok;
    base = cap_n[g];
    dc0  = done_cnt[g];
    t = 0;
    while (req_ready[g] !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, ".ready"}, 32'(req_ready[g]), 32'd1);
    req_valid[g] = 1'b1;
    req_value[g] = val;
    @(negedge clk);
    req_valid[g] = 1'b0;
    req_value[g] = ~val;
    eb = exp[0];
    chk({tag, ".first_start"}, 32'(start[g]), 32'd1);
    chk({tag, ".first_data"}, 32'(data[g]), 32'(eb));
    chk({tag, ".ready_low"}, 32'(req_ready[g]), 32'd0);
    d0 = data[g];
    hold_ok = 1'b1;
    t = 0;
    while (busy[g] !== 1'b1 && t < 200) begin
      if (start[g] !== 1'b1 || data[g] !== d0) hold_ok = 1'b0;
      @(negedge clk);
      t++;
    end
    chk({tag, ".start_hold"}, 32'(hold_ok), 32'd1);
    wait_done(g, tag);
    chk({tag, ".done_latency"}, 32'(cyc), 32'(fall_cyc[g] + 1));
    chk({tag, ".ready_at_done"}, 32'(req_ready[g]), 32'd1);
    chk({tag, ".nbytes"}, 32'(cap_n[g] - base), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      eb = exp[i];
      chk($sformatf("%s.byte%0d", tag, i), 32'(cap[g][base + i]), 32'(eb));
    end
    @(negedge clk);
    chk({tag, ".done_pulse_end"}, 32'(done[g]), 32'd0);
    chk({tag, ".done_count"}, 32'(done_cnt[g] - dc0), 32'd1);
  endtask

  initial begin
    int base, dc0, e0, t;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      req_valid[g]  = 1'b0;
      req_value[g]  = 32'h0;
      echo_valid[g] = 1'b0;
      echo_data[g]  = 8'h00;
      stall_en[g]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst%0d.start", g), 32'(start[g]), 32'd0);
      chk($sformatf("rst%0d.data", g), 32'(data[g]), 32'h00);
      chk($sformatf("rst%0d.done", g), 32'(done[g]), 32'd0);
      chk($sformatf("rst%0d.echo_ready", g), 32'(echo_ready[g]), 32'd0);
      chk($sformatf("rst%0d.req_ready", g), 32'(req_ready[g]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 3; g++)
      chk($sformatf("rel%0d.req_ready", g), 32'(req_ready[g]), 32'd1);
    @(negedge clk);

    run_print(0, 32'h1234ABCD, "0x1234ABCD\r\n", "t1");
    run_print(1, 32'h000000F0, "f0\r\n", "t2a");
    run_print(1, 32'h00000000, "0\r\n", "t2b");
    run_print(1, 32'h0A000000, "a000000\r\n", "t2c");
    run_print(2, 32'h000003FF, "3FF", "t3a");
    run_print(2, 32'h00000005, "005", "t3b");

    // request and echo together: print first, echo afterwards
    base = cap_n[0];
    e0   = echo_cnt[0];
    req_valid[0]  = 1'b1;
    req_value[0]  = 32'h00000001;
    echo_valid[0] = 1'b1;
    echo_data[0]  = 8'h41;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("t4.no_echo_ready_at_accept", 32'(echo_ready[0]), 32'd0);
    chk("t4.first_data", 32'(data[0]), 32'h30);
    wait_done(0, "t4.print");
    chk("t4.no_echo_before_done", 32'(echo_cnt[0] - e0), 32'd0);
    t = 0;
    while (echo_ready[0] !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("t4.echo_ready_delay", 32'(t), 32'd1);
    echo_valid[0] = 1'b0;
    echo_data[0]  = 8'h5A;
    wait_done(0, "t4.echo");
    @(negedge clk);
    chk("t4.nbytes", 32'(cap_n[0] - base), 32'd13);
    chk("t4.last_digit", 32'(cap[0][base + 9]), 32'h31);
    chk("t4.lf", 32'(cap[0][base + 11]), 32'h0A);
    chk("t4.echo_byte", 32'(cap[0][base + 12]), 32'h41);
    chk("t4.echo_count", 32'(echo_cnt[0] - e0), 32'd1);

    // reset while the third byte is in flight
    base = cap_n[0];
    dc0  = done_cnt[0];
    req_valid[0] = 1'b1;
    req_value[0] = 32'hCAFE0001;
    @(negedge clk);
    req_valid[0] = 1'b0;
    t = 0;
    while ((cap_n[0] - base) < 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("t5.in_busy", 32'(busy[0]), 32'd1);
    chk("t5.third_byte", 32'(cap[0][base + 2]), 32'h43);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5.start", 32'(start[0]), 32'd0);
    chk("t5.data", 32'(data[0]), 32'h00);
    chk("t5.done", 32'(done[0]), 32'd0);
    chk("t5.echo_ready", 32'(echo_ready[0]), 32'd0);
    chk("t5.req_ready_in_rst", 32'(req_ready[0]), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t5.req_ready_after", 32'(req_ready[0]), 32'd1);
    repeat (40) @(negedge clk);
    chk("t5.no_done", 32'(done_cnt[0] - dc0), 32'd0);
    chk("t5.abandoned", 32'(cap_n[0] - base), 32'd3);
    run_print(0, 32'h0000BEEF, "0x0000BEEF\r\n", "t5.after");

    // transmitter slow to respond: start/data must hold
    stall_en[2] = 1'b1;
    run_print(2, 32'h000002A5, "2A5", "t6");
    stall_en[2] = 1'b0;

    for (int g = 0; g < 3; g++)
      chk($sformatf("handshake_rules%0d", g), 32'(viol_cnt[g]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
